// File: rtl/rggen_apb_initiator_if.sv
// APB bus bundle shared by the initiator and register-block adapters.
interface rggen_apb_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32
);
  logic                     psel;
  logic                     penable;
  logic [ADDRESS_WIDTH-1:0] paddr;
  logic [2:0]               pprot;
  logic                     pwrite;
  logic [BUS_WIDTH/8-1:0]   pstrb;
  logic [BUS_WIDTH-1:0]     pwdata;
  logic                     pready;
  logic [BUS_WIDTH-1:0]     prdata;
  logic                     pslverr;

  modport master (
    output psel, penable, paddr, pprot, pwrite, pstrb, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pprot, pwrite, pstrb, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/rggen_apb_initiator.sv
// APB requester: turns one outstanding valid/ready command into a SETUP/ACCESS
// transfer and returns data/status on a valid/ready response channel.
module rggen_apb_initiator #(
  parameter int ADDRESS_WIDTH         = 16,
  parameter int BUS_WIDTH             = 32,
  parameter int TIMEOUT_CYCLES        = 256,
  parameter int TIMEOUT_COUNTER_WIDTH = 9
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic                     i_cmd_write,
  input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
  input  logic [BUS_WIDTH-1:0]     i_cmd_write_data,
  input  logic [BUS_WIDTH/8-1:0]   i_cmd_strobe,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
  output logic [1:0]               o_rsp_status,
  rggen_apb_if.master              apb_if
);
  localparam int STRB_WIDTH = BUS_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK =
    ~ADDRESS_WIDTH'((1 << ADDR_LSB) - 1);
  localparam logic [1:0] STATUS_OKAY    = 2'b00;
  localparam logic [1:0] STATUS_SLVERR  = 2'b01;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESPONSE} state_e;

  state_e                           state_q, state_d;
  logic                             psel_q, psel_d;
  logic                             penable_q, penable_d;
  logic [ADDRESS_WIDTH-1:0]         paddr_q, paddr_d;
  logic                             pwrite_q, pwrite_d;
  logic [STRB_WIDTH-1:0]            pstrb_q, pstrb_d;
  logic [BUS_WIDTH-1:0]             pwdata_q, pwdata_d;
  logic                             rsp_valid_q, rsp_valid_d;
  logic [BUS_WIDTH-1:0]             rsp_data_q, rsp_data_d;
  logic [1:0]                       rsp_status_q, rsp_status_d;
  logic [TIMEOUT_COUNTER_WIDTH-1:0] count_q, count_d;
  logic                             timeout_hit;

  // The abort fires on the last permitted wait cycle; pready still takes priority.
  if (TIMEOUT_CYCLES != 0) begin : g_timeout
    localparam int unsigned LAST = TIMEOUT_CYCLES - 1;
    assign timeout_hit = (count_q == TIMEOUT_COUNTER_WIDTH'(LAST));
  end else begin : g_no_timeout
    assign timeout_hit = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (i_cmd_valid) state_d = SETUP;
      SETUP:    state_d = ACCESS;
      ACCESS:   if (apb_if.pready || timeout_hit) state_d = RESPONSE;
      RESPONSE: if (i_rsp_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    psel_d       = psel_q;
    penable_d    = penable_q;
    paddr_d      = paddr_q;
    pwrite_d     = pwrite_q;
    pstrb_d      = pstrb_q;
    pwdata_d     = pwdata_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    count_d      = count_q;
    case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = i_cmd_address & ADDR_MASK;
          pwrite_d  = i_cmd_write;
          pstrb_d   = i_cmd_write ? i_cmd_strobe : '0;
          pwdata_d  = i_cmd_write ? i_cmd_write_data : '0;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        count_d   = '0;
      end
      ACCESS: begin
        if (apb_if.pready) begin
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_data_d   = pwrite_q ? '0 : apb_if.prdata;
          rsp_status_d = apb_if.pslverr ? STATUS_SLVERR : STATUS_OKAY;
        end else if (timeout_hit) begin
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_data_d   = '0;
          rsp_status_d = STATUS_TIMEOUT;
        end else begin
          count_d = count_q + TIMEOUT_COUNTER_WIDTH'(1);
        end
      end
      RESPONSE: begin
        if (i_rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      pstrb_q      <= '0;
      pwdata_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_status_q <= STATUS_OKAY;
      count_q      <= '0;
    end else begin
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      paddr_q      <= paddr_d;
      pwrite_q     <= pwrite_d;
      pstrb_q      <= pstrb_d;
      pwdata_q     <= pwdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      count_q      <= count_d;
    end
  end

  assign o_cmd_ready     = (state_q == IDLE);
  assign o_rsp_valid     = rsp_valid_q;
  assign o_rsp_read_data = rsp_data_q;
  assign o_rsp_status    = rsp_status_q;

  assign apb_if.psel    = psel_q;
  assign apb_if.penable = penable_q;
  assign apb_if.paddr   = paddr_q;
  assign apb_if.pprot   = 3'b000;
  assign apb_if.pwrite  = pwrite_q;
  assign apb_if.pstrb   = pstrb_q;
  assign apb_if.pwdata  = pwdata_q;
endmodule

// File: tb/tb_rggen_apb_initiator.sv
// Bench for rggen_apb_initiator: directed table, random transfers, reset abort.
module tb_rggen_apb_initiator;
  localparam int TMO = 8;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_address;
  logic [31:0] cmd_write_data;
  logic [3:0]  cmd_strobe;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_read_data;
  logic [1:0]  rsp_status;

  int n_checks = 0;
  int n_fail   = 0;

  rggen_apb_if #(.ADDRESS_WIDTH(16), .BUS_WIDTH(32)) apb_if ();

  rggen_apb_initiator #(
    .ADDRESS_WIDTH(16), .BUS_WIDTH(32),
    .TIMEOUT_CYCLES(TMO), .TIMEOUT_COUNTER_WIDTH(4)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_address(cmd_address), .i_cmd_write_data(cmd_write_data),
    .i_cmd_strobe(cmd_strobe),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_read_data(rsp_read_data), .o_rsp_status(rsp_status),
    .apb_if(apb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;      // ACCESS cycles the slave holds pready low
    logic [31:0] rdata;
    logic        slverr;
    int          delay;      // cycles rsp_ready stays low after rsp_valid
    logic [15:0] exp_paddr;
    int          exp_acc;
    int          exp_lat;    // cycles from accept cycle to first rsp_valid cycle
    logic [1:0]  exp_status;
    logic [31:0] exp_data;
  } vec_t;

  function automatic vec_t mk(logic w, logic [15:0] a, logic [31:0] wd, logic [3:0] s,
                              int wt, logic [31:0] rd, logic se, int dl,
                              logic [15:0] ep, int ea, int el, logic [1:0] es,
                              logic [31:0] ed);
    vec_t v;
    v.write = w; v.addr = a; v.wdata = wd; v.strb = s; v.waits = wt; v.rdata = rd;
    v.slverr = se; v.delay = dl; v.exp_paddr = ep; v.exp_acc = ea; v.exp_lat = el;
    v.exp_status = es; v.exp_data = ed;
    return v;
  endfunction

  // Reference: a transfer either completes on the first ready ACCESS cycle or
  // is cut off after TMO cycles; response appears two cycles past the ACCESS phase.
  function automatic vec_t model(vec_t v);
    vec_t r = v;
    logic timed_out = (v.waits >= TMO);
    r.exp_paddr  = {v.addr[15:2], 2'b00};
    r.exp_acc    = timed_out ? TMO : v.waits + 1;
    r.exp_lat    = 2 + r.exp_acc;
    r.exp_status = timed_out ? 2'd2 : (v.slverr ? 2'd1 : 2'd0);
    r.exp_data   = (timed_out || v.write) ? 32'h0 : v.rdata;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Entered and left at a negedge.
  task automatic run_xfer(input int idx, input vec_t v);
    int lat, setups, accs;
    logic captured, stable;
    logic [15:0] cap_addr;
    logic        cap_write;
    logic [3:0]  cap_strb;
    logic [31:0] cap_wdata, r_data;
    logic [1:0]  r_status;
    check("cmd_ready_before_accept", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = v.write; cmd_address = v.addr;
    cmd_write_data = v.wdata; cmd_strobe = v.strb;
    apb_if.prdata = v.rdata; apb_if.pslverr = v.slverr; apb_if.pready = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_write = ~v.write; cmd_address = ~v.addr;
    cmd_write_data = ~v.wdata; cmd_strobe = ~v.strb;
    lat = 0; setups = 0; accs = 0; captured = 1'b0; stable = 1'b1;
    cap_addr = '0; cap_write = 1'b0; cap_strb = '0; cap_wdata = '0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = c;
        apb_if.pready = 1'b0;
      end else begin
        if (apb_if.psel) begin
          if (!captured) begin
            cap_addr = apb_if.paddr; cap_write = apb_if.pwrite;
            cap_strb = apb_if.pstrb; cap_wdata = apb_if.pwdata; captured = 1'b1;
          end else if (apb_if.paddr !== cap_addr || apb_if.pwrite !== cap_write ||
                       apb_if.pstrb !== cap_strb || apb_if.pwdata !== cap_wdata) begin
            stable = 1'b0;
          end
          if (apb_if.pprot !== 3'b000) stable = 1'b0;
        end
        if (apb_if.psel && !apb_if.penable) setups++;
        if (apb_if.psel && apb_if.penable) begin
          accs++;
          apb_if.pready = (accs > v.waits);
        end else begin
          apb_if.pready = 1'b0;
        end
      end
    end
    check("rsp_latency", lat, v.exp_lat);
    check("setup_cycles", setups, 1);
    check("access_cycles", accs, v.exp_acc);
    check("paddr", cap_addr, v.exp_paddr);
    check("pwrite", cap_write, v.write);
    check("pstrb", cap_strb, v.write ? v.strb : 4'h0);
    check("pwdata", cap_wdata, v.write ? v.wdata : 32'h0);
    check("apb_held_stable", stable, 1'b1);
    if (lat == 0) begin
      rst_n = 1'b0; #2; rst_n = 1'b1;
      @(negedge clk);
      return;
    end
    r_data = rsp_read_data; r_status = rsp_status;
    check("rsp_read_data", r_data, v.exp_data);
    check("rsp_status", r_status, v.exp_status);
    check("cmd_ready_in_response", cmd_ready, 1'b0);
    rsp_ready = 1'b0;
    for (int d = 0; d < v.delay; d++) begin
      @(negedge clk);
      check("rsp_hold", {rsp_valid, cmd_ready, apb_if.psel, rsp_status, rsp_read_data},
            {1'b1, 1'b0, 1'b0, r_status, r_data});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("after_handshake", {rsp_valid, cmd_ready}, 2'b01);
    $display("xfer %0d: %s addr=%h waits=%0d lat=%0d acc=%0d status=%0d data=%h",
             idx, v.write ? "WR" : "RD", v.addr, v.waits, lat, accs, r_status, r_data);
  endtask

  vec_t tab[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0;
    cmd_write_data = '0; cmd_strobe = '0; rsp_ready = 1'b0;
    apb_if.pready = 1'b0; apb_if.prdata = '0; apb_if.pslverr = 1'b0;

    tab[0] = mk(1, 16'h0013, 32'hA5A5_5A5A, 4'hF,   0, 32'h0000_0000, 0, 0, 16'h0010, 1,  3, 2'd0, 32'h0);
    tab[1] = mk(0, 16'h0020, 32'hFFFF_0000, 4'hF,   3, 32'h1234_5678, 0, 0, 16'h0020, 4,  6, 2'd0, 32'h1234_5678);
    tab[2] = mk(0, 16'h0046, 32'h0,         4'h0,   1, 32'hDEAD_BEEF, 1, 0, 16'h0044, 2,  4, 2'd1, 32'hDEAD_BEEF);
    tab[3] = mk(0, 16'h0100, 32'h0,         4'h0, 255, 32'hFFFF_FFFF, 1, 0, 16'h0100, 8, 10, 2'd2, 32'h0);
    tab[4] = mk(1, 16'h0104, 32'h0BAD_F00D, 4'h5,   2, 32'h1357_2468, 0, 0, 16'h0104, 3,  5, 2'd0, 32'h0);
    tab[5] = mk(0, 16'h0008, 32'h0,         4'h0,   7, 32'h0000_55AA, 0, 0, 16'h0008, 8, 10, 2'd0, 32'h0000_55AA);
    tab[6] = mk(1, 16'h00FF, 32'h1122_3344, 4'h3,   0, 32'h9999_9999, 1, 0, 16'h00FC, 1,  3, 2'd1, 32'h0);
    tab[7] = mk(0, 16'h0032, 32'h0,         4'h0,   0, 32'hCAFE_F00D, 0, 5, 16'h0030, 1,  3, 2'd0, 32'hCAFE_F00D);

    #1;
    check("reset_apb", {apb_if.psel, apb_if.penable, apb_if.paddr, apb_if.pprot,
                        apb_if.pwrite, apb_if.pstrb, apb_if.pwdata}, '0);
    check("reset_rsp", {rsp_valid, rsp_read_data, rsp_status}, '0);
    check("reset_cmd_ready", cmd_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {cmd_ready, rsp_valid, apb_if.psel}, 3'b100);

    for (int i = 0; i < 8; i++) run_xfer(i, tab[i]);

    // Reset pulled in the middle of an ACCESS phase.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 16'h0040;
    apb_if.pready = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("in_access_before_reset", {apb_if.psel, apb_if.penable}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_drop", {apb_if.psel, apb_if.penable, rsp_valid, cmd_ready}, 4'b0001);
    check("async_reset_paddr", apb_if.paddr, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("after_reset_quiet", {rsp_valid, apb_if.psel, cmd_ready}, 3'b001);
    end
    run_xfer(100, tab[1]);

    for (int i = 0; i < 30; i++) begin
      vec_t v;
      v.write = 1'($urandom); v.addr = 16'($urandom); v.wdata = $urandom;
      v.strb = 4'($urandom); v.waits = int'($urandom_range(0, 10));
      v.rdata = $urandom; v.slverr = 1'($urandom); v.delay = int'($urandom_range(0, 3));
      run_xfer(200 + i, model(v));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
